// File: rtl/i2c_slave_core.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : i2c_slave_core
// Description : I2C slave with a 7-bit address in standard mode. SCL and SDA
//               are oversampled by the system clock, so SCL is never used as
//               a clock. Bytes written by the master are ACKed and shown on
//               rx_data_out. Reads return the last byte received, which acts
//               as a loopback register.
// Ports       : clk          - system clock, the only clock (<= SCL period/16)
//               rst_n        - synchronous active-low reset
//               scl          - I2C clock from the master, synchronised as data
//               sda          - I2C data, open-drain (drives 0 or Z only)
//               rx_data_out  - last byte written by the master
//               rx_valid     - one-clk pulse when rx_data_out is updated
// Revision    : 1.0 - initial release
// ============================================================================
module i2c_slave_core #(
    parameter logic [6:0] SLAVE_ADDR  = 7'h53,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       scl,
    inout  wire        sda,
    output logic [7:0] rx_data_out,
    output logic       rx_valid
);

    // Fewer than two synchroniser flops is not metastability-safe.
    localparam int c_SYNC = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_ADDR     = 3'd1,
        ST_ADDR_ACK = 3'd2,
        ST_RX_BYTE  = 3'd3,
        ST_RX_ACK   = 3'd4,
        ST_TX_BYTE  = 3'd5,
        ST_TX_ACK   = 3'd6,
        ST_IGNORE   = 3'd7
    } state_t;

    // Input conditioning
    logic [c_SYNC-1:0] r_scl_sync_q, w_scl_sync_d;
    logic [c_SYNC-1:0] r_sda_sync_q, w_sda_sync_d;
    logic              r_scl_prev_q, w_scl_prev_d;
    logic              r_sda_prev_q, w_sda_prev_d;

    // Protocol state
    state_t            r_state_q, w_state_d;
    logic [3:0]        r_bit_cnt_q, w_bit_cnt_d;
    logic [7:0]        r_shift_q, w_shift_d;
    logic              r_rw_q, w_rw_d;
    logic [7:0]        r_tx_shift_q, w_tx_shift_d;
    logic              r_sda_oe_q, w_sda_oe_d;
    logic [7:0]        r_rx_data_q, w_rx_data_d;
    logic              r_rx_valid_q, w_rx_valid_d;

    logic w_s_scl, w_s_sda;
    logic w_scl_rise, w_scl_fall, w_start, w_stop;
    logic w_addr_match;

    assign w_s_scl = r_scl_sync_q[c_SYNC-1];
    assign w_s_sda = r_sda_sync_q[c_SYNC-1];

    assign w_scl_rise = w_s_scl & ~r_scl_prev_q;
    assign w_scl_fall = ~w_s_scl & r_scl_prev_q;
    assign w_start    = r_sda_prev_q & ~w_s_sda & w_s_scl;
    assign w_stop     = ~r_sda_prev_q & w_s_sda & w_s_scl;

    // General call (address 0) is never answered, whatever SLAVE_ADDR is.
    assign w_addr_match = (r_shift_q[7:1] == SLAVE_ADDR) && (r_shift_q[7:1] != 7'h00);

    // Open-drain pad: pull low or float, never drive high.
    assign sda         = r_sda_oe_q ? 1'b0 : 1'bz;
    assign rx_data_out = r_rx_data_q;
    assign rx_valid    = r_rx_valid_q;

    always_comb begin
        w_scl_sync_d = {r_scl_sync_q[c_SYNC-2:0], scl};
        w_sda_sync_d = {r_sda_sync_q[c_SYNC-2:0], sda};
        w_scl_prev_d = w_s_scl;
        w_sda_prev_d = w_s_sda;

        w_state_d    = r_state_q;
        w_bit_cnt_d  = r_bit_cnt_q;
        w_shift_d    = r_shift_q;
        w_rw_d       = r_rw_q;
        w_tx_shift_d = r_tx_shift_q;
        w_sda_oe_d   = r_sda_oe_q;
        w_rx_data_d  = r_rx_data_q;
        w_rx_valid_d = 1'b0;

        // Bus conditions win over any SCL edge seen in the same clock.
        if (w_start) begin
            w_state_d   = ST_ADDR;
            w_bit_cnt_d = 4'd0;
            w_sda_oe_d  = 1'b0;
        end else if (w_stop) begin
            w_state_d  = ST_IDLE;
            w_sda_oe_d = 1'b0;
        end else begin
            unique case (r_state_q)
                ST_IDLE, ST_IGNORE: begin
                    w_sda_oe_d = 1'b0;
                end
                ST_ADDR: begin
                    if (w_scl_rise && (r_bit_cnt_q != 4'd8)) begin
                        w_shift_d   = {r_shift_q[6:0], w_s_sda};
                        w_bit_cnt_d = r_bit_cnt_q + 4'd1;
                    end else if (w_scl_fall && (r_bit_cnt_q == 4'd8)) begin
                        if (w_addr_match) begin
                            w_sda_oe_d = 1'b1;
                            w_rw_d     = r_shift_q[0];
                            w_state_d  = ST_ADDR_ACK;
                        end else begin
                            w_sda_oe_d = 1'b0;
                            w_state_d  = ST_IGNORE;
                        end
                    end
                end
                ST_ADDR_ACK: begin
                    if (w_scl_fall) begin
                        if (!r_rw_q) begin
                            w_sda_oe_d  = 1'b0;
                            w_bit_cnt_d = 4'd0;
                            w_state_d   = ST_RX_BYTE;
                        end else begin
                            // Read: bit7 goes out on this same falling edge.
                            w_sda_oe_d   = ~r_rx_data_q[7];
                            w_tx_shift_d = {r_rx_data_q[6:0], 1'b0};
                            w_bit_cnt_d  = 4'd1;
                            w_state_d    = ST_TX_BYTE;
                        end
                    end
                end
                ST_RX_BYTE: begin
                    if (w_scl_rise && (r_bit_cnt_q != 4'd8)) begin
                        w_shift_d   = {r_shift_q[6:0], w_s_sda};
                        w_bit_cnt_d = r_bit_cnt_q + 4'd1;
                        if (r_bit_cnt_q == 4'd7) begin
                            w_rx_data_d  = {r_shift_q[6:0], w_s_sda};
                            w_rx_valid_d = 1'b1;
                        end
                    end else if (w_scl_fall && (r_bit_cnt_q == 4'd8)) begin
                        w_sda_oe_d = 1'b1;
                        w_state_d  = ST_RX_ACK;
                    end
                end
                ST_RX_ACK: begin
                    if (w_scl_fall) begin
                        w_sda_oe_d  = 1'b0;
                        w_bit_cnt_d = 4'd0;
                        w_state_d   = ST_RX_BYTE;
                    end
                end
                ST_TX_BYTE: begin
                    // bit_cnt counts bits already placed on the bus.
                    if (w_scl_fall) begin
                        if (r_bit_cnt_q == 4'd8) begin
                            w_sda_oe_d = 1'b0;
                            w_state_d  = ST_TX_ACK;
                        end else begin
                            w_sda_oe_d   = ~r_tx_shift_q[7];
                            w_tx_shift_d = {r_tx_shift_q[6:0], 1'b0};
                            w_bit_cnt_d  = r_bit_cnt_q + 4'd1;
                        end
                    end
                end
                ST_TX_ACK: begin
                    if (w_scl_rise) begin
                        if (!w_s_sda) begin
                            w_tx_shift_d = r_rx_data_q;
                            w_bit_cnt_d  = 4'd0;
                            w_state_d    = ST_TX_BYTE;
                        end else begin
                            w_state_d = ST_IGNORE;
                        end
                    end
                end
                default: begin
                    w_sda_oe_d = 1'b0;
                    w_state_d  = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            // Synchronisers start at the idle bus level to avoid false edges.
            r_scl_sync_q <= '1;
            r_sda_sync_q <= '1;
            r_scl_prev_q <= 1'b1;
            r_sda_prev_q <= 1'b1;
            r_state_q    <= ST_IDLE;
            r_bit_cnt_q  <= 4'd0;
            r_shift_q    <= 8'h00;
            r_rw_q       <= 1'b0;
            r_tx_shift_q <= 8'h00;
            r_sda_oe_q   <= 1'b0;
            r_rx_data_q  <= 8'h00;
            r_rx_valid_q <= 1'b0;
        end else begin
            r_scl_sync_q <= w_scl_sync_d;
            r_sda_sync_q <= w_sda_sync_d;
            r_scl_prev_q <= w_scl_prev_d;
            r_sda_prev_q <= w_sda_prev_d;
            r_state_q    <= w_state_d;
            r_bit_cnt_q  <= w_bit_cnt_d;
            r_shift_q    <= w_shift_d;
            r_rw_q       <= w_rw_d;
            r_tx_shift_q <= w_tx_shift_d;
            r_sda_oe_q   <= w_sda_oe_d;
            r_rx_data_q  <= w_rx_data_d;
            r_rx_valid_q <= w_rx_valid_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_i2c_slave_core.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_i2c_slave_core
// Description : Self-checking bench for i2c_slave_core. An I2C master model
//               drives SCL/SDA, while a transaction-level model tracks the
//               loopback byte and rx_valid count. A compare process checks
//               the bus and outputs at every SCL-high sample point.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_i2c_slave_core;

    localparam int         c_Q    = 8;      // clocks per SCL quarter period
    localparam logic [6:0] c_ADDR = 7'h53;

    logic clk       = 1'b0;
    logic rst_n     = 1'b0;
    logic scl       = 1'b1;
    logic m_sda_low = 1'b0;
    wire  sda;
    logic [7:0] rx_data_out;
    logic       rx_valid;

    pullup (sda);
    assign sda = m_sda_low ? 1'b0 : 1'bz;

    i2c_slave_core #(
        .SLAVE_ADDR  (c_ADDR),
        .SYNC_STAGES (2)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .scl         (scl),
        .sda         (sda),
        .rx_data_out (rx_data_out),
        .rx_valid    (rx_valid)
    );

    always #5 clk = ~clk;

    int         n_checks     = 0;
    int         n_fail       = 0;
    logic [7:0] model_rx     = 8'h00;
    int         model_pulses = 0;
    int         dut_pulses   = 0;
    logic       chk_stb      = 1'b0;
    logic       exp_sda      = 1'b1;
    logic       quiet_en     = 1'b0;
    logic       prev_valid   = 1'b0;
    string      chk_name     = "";

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Compare process: sampled on the falling clock edge.
    initial forever begin
        @(negedge clk);
        if (rx_valid) begin
            check("rx_valid single clk", 32'(prev_valid), 32'd0);
            dut_pulses++;
        end
        prev_valid = rx_valid;
        if (chk_stb) begin
            check({chk_name, " sda"}, 32'(sda), 32'(exp_sda));
            check({chk_name, " rx_data_out"}, 32'(rx_data_out), 32'(model_rx));
            check({chk_name, " rx_valid count"}, 32'(dut_pulses), 32'(model_pulses));
        end
        if (quiet_en && !m_sda_low)
            check("slave silent", 32'(sda), 32'd1);
    end

    // One SCL pulse: master drives drive_one (1 = release), the slave is
    // expected to pull low iff slave_low. rd is the bus value at mid-high.
    task automatic clk_bit(input logic drive_one, input logic slave_low,
                           input string name, output logic rd);
        m_sda_low = ~drive_one;
        tick(c_Q);
        scl = 1'b1;
        tick(c_Q);
        exp_sda  = drive_one & ~slave_low;
        chk_name = name;
        chk_stb  = 1'b1;
        rd       = sda;
        tick(1);
        chk_stb  = 1'b0;
        tick(c_Q - 1);
        scl = 1'b0;
        tick(c_Q);
    endtask

    task automatic i2c_start();
        m_sda_low = 1'b0;
        tick(c_Q);
        scl = 1'b1;
        tick(c_Q);
        m_sda_low = 1'b1;
        tick(c_Q);
        scl = 1'b0;
        tick(c_Q);
    endtask

    task automatic i2c_stop();
        m_sda_low = 1'b1;
        tick(c_Q);
        scl = 1'b1;
        tick(c_Q);
        m_sda_low = 1'b0;
        tick(c_Q);
    endtask

    // Sends a byte MSB first plus the ACK slot. For an addressed data byte
    // the model learns the byte just before its last bit, since the slave
    // latches it on that bit's rising edge.
    task automatic send_byte(input logic [7:0] b, input logic addressed,
                             input logic data_byte, input string name,
                             output logic ack_rd);
        logic rd;
        for (int i = 7; i >= 0; i--) begin
            if (i == 0 && data_byte && addressed) begin
                model_rx = b;
                model_pulses++;
            end
            clk_bit(b[i], 1'b0, name, rd);
        end
        clk_bit(1'b1, addressed, {name, " ack slot"}, ack_rd);
    endtask

    // Full write transaction; acks = number of ACK slots read as 0.
    task automatic write_txn(input logic [6:0] a, input int n,
                             input logic [7:0] d0, input logic [7:0] d1,
                             input logic [7:0] d2, output int acks);
        logic [7:0] d [3];
        logic       hit;
        logic       ack_rd;
        d    = '{d0, d1, d2};
        hit  = (a == c_ADDR) && (a != 7'h00);
        acks = 0;
        i2c_start();
        quiet_en = ~hit;
        send_byte({a, 1'b0}, hit, 1'b0, "wr addr", ack_rd);
        if (!ack_rd) acks++;
        for (int k = 0; k < n; k++) begin
            send_byte(d[k], hit, 1'b1, "wr data", ack_rd);
            if (!ack_rd) acks++;
        end
        quiet_en = 1'b0;
        i2c_stop();
    endtask

    // Read transaction from this slave; master ACKs all but the last byte.
    task automatic read_txn(input int n, output logic [7:0] r0, output logic [7:0] r1,
                            output logic addr_ack);
        logic [7:0] r [2];
        logic       rd;
        r = '{8'h00, 8'h00};
        i2c_start();
        send_byte({c_ADDR, 1'b1}, 1'b1, 1'b0, "rd addr", rd);
        addr_ack = ~rd;
        for (int k = 0; k < n; k++) begin
            for (int i = 7; i >= 0; i--) begin
                clk_bit(1'b1, ~model_rx[i], "rd data", rd);
                r[k][i] = rd;
            end
            clk_bit((k == n - 1) ? 1'b1 : 1'b0, 1'b0, "master ack", rd);
        end
        m_sda_low = 1'b0;
        tick(2);
        check("sda released after NACK", 32'(sda), 32'd1);
        i2c_stop();
        r0 = r[0];
        r1 = r[1];
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int         acks;
        int         p0;
        logic [7:0] b0, b1;
        logic       aack;
        logic       rd;

        // Reset state
        tick(4);
        check("reset rx_data_out", 32'(rx_data_out), 32'h00);
        check("reset rx_valid", 32'(rx_valid), 32'd0);
        check("reset sda", 32'(sda), 32'd1);
        rst_n = 1'b1;
        tick(c_Q);

        // Write one byte 0x13
        p0 = dut_pulses;
        write_txn(c_ADDR, 1, 8'h13, 8'h00, 8'h00, acks);
        check("write1 acks", 32'(acks), 32'd2);
        check("write1 rx_data_out", 32'(rx_data_out), 32'h13);
        check("write1 pulses", 32'(dut_pulses - p0), 32'd1);

        // Read it back
        read_txn(1, b0, b1, aack);
        check("read1 addr ack", 32'(aack), 32'd1);
        check("read1 byte", 32'(b0), 32'h13);

        // Address 0x60 read: no ACK, no drive until STOP
        i2c_start();
        quiet_en = 1'b1;
        send_byte(8'hC1, 1'b0, 1'b0, "bad addr", rd);
        check("bad addr ack slot", 32'(rd), 32'd1);
        for (int i = 0; i < 9; i++) clk_bit(1'b1, 1'b0, "ignored", rd);
        quiet_en = 1'b0;
        i2c_stop();
        check("bad addr rx_data_out", 32'(rx_data_out), 32'h13);

        // General call is not answered
        write_txn(7'h00, 1, 8'hFF, 8'h00, 8'h00, acks);
        check("general call acks", 32'(acks), 32'd0);
        check("general call rx_data_out", 32'(rx_data_out), 32'h13);

        // Multi-byte write
        p0 = dut_pulses;
        write_txn(c_ADDR, 2, 8'h0D, 8'h15, 8'h00, acks);
        check("multi acks", 32'(acks), 32'd3);
        check("multi pulses", 32'(dut_pulses - p0), 32'd2);
        check("multi rx_data_out", 32'(rx_data_out), 32'h15);

        // Two-byte read, master ACK then NACK
        read_txn(2, b0, b1, aack);
        check("read2 addr ack", 32'(aack), 32'd1);
        check("read2 byte0", 32'(b0), 32'h15);
        check("read2 byte1", 32'(b1), 32'h15);

        // Reset in the middle of a received byte
        i2c_start();
        send_byte({c_ADDR, 1'b0}, 1'b1, 1'b0, "pre-reset addr", rd);
        clk_bit(1'b1, 1'b0, "partial", rd);
        clk_bit(1'b0, 1'b0, "partial", rd);
        clk_bit(1'b1, 1'b0, "partial", rd);
        rst_n = 1'b0;
        tick(1);
        model_rx = 8'h00;
        check("mid reset sda", 32'(sda), 32'd1);
        check("mid reset rx_data_out", 32'(rx_data_out), 32'h00);
        check("mid reset rx_valid", 32'(rx_valid), 32'd0);
        rst_n = 1'b1;
        tick(c_Q);

        // Normal write after reset
        p0 = dut_pulses;
        write_txn(c_ADDR, 1, 8'h5A, 8'h00, 8'h00, acks);
        check("post-reset acks", 32'(acks), 32'd2);
        check("post-reset rx_data_out", 32'(rx_data_out), 32'h5A);
        check("post-reset pulses", 32'(dut_pulses - p0), 32'd1);

        tick(c_Q);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
